interrupt_controller: RTL and testbench
=======================================

// Module: interrupt_controller
// PURPOSE
//  Prioritised, vectored interrupt controller between external lines int_e[7:0] and the CPU control unit.
//  Edge-detects and latches requests, applies mask/global enable, tracks in-service levels for nesting,
//  and presents one request + 16-bit handler vector until the CPU acknowledges the call (calli path).
//  Retires the active level on reti. Config registers are on a small memory-mapped port from the datapath.
// PARAMETERS
//  N_INT        8        number of interrupt lines (index 0 = highest priority)
//  VEC_STRIDE   4        address distance between handler entries (words)
//  VEC_BASE_RST 16'h0010 reset value of VBASE register
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   synchronous, active-high
//  int_e       in   8   raw interrupt lines, rising edge = request
//  we          in   1   register write strobe
//  addr        in   2   register select: 0 MASK, 1 PEND, 2 INSV (RO), 3 VBASE
//  wdata       in   16  write data
//  rdata       out  16  read data for addr, combinational, zero-extended
//  int_ack     in   1   1-cycle pulse: CPU took the call this cycle
//  int_ret     in   1   1-cycle pulse: CPU executed reti this cycle
//  int_req     out  1   interrupt request to control unit
//  int_vector  out  16  handler address, valid while int_req=1
//  int_id      out  3   index of requested line, valid while int_req=1
// BEHAVIOUR
//  Reset: MASK=0, GIE=0, PEND=0, INSV=0, VBASE=VEC_BASE_RST, prev_e=int_e sampled as 0,
//   state=IDLE, int_req=0, int_vector=0, int_id=0. Reset mid-request drops int_req next cycle, no ack needed.
//  Edge detect: prev_e <= int_e each cycle; PEND[i] set when int_e[i] & ~prev_e[i]. Level-high lines
//   do not re-trigger. Set beats a same-cycle W1C clear of the same bit.
//  Registers: MASK[7:0]=enable per line, MASK[15]=GIE; PEND write-1-to-clear; INSV read-only;
//   VBASE full 16 bits. Writes to reserved MASK bits 14:8 ignored, read as 0.
//  Eligible set E = PEND & MASK[7:0] & ~INSV, qualified by GIE. Winner w = lowest set index of E.
//  Nesting: w is requestable only if INSV==0 or w < lowest set index of INSV (strictly higher priority).
//  FSM states:
//   IDLE: int_req=0. If a requestable w exists -> REQ next cycle, latch int_id=w,
//    int_vector = VBASE + w*VEC_STRIDE (16-bit, wraps modulo 2^16).
//   REQ: int_req=1; int_id/int_vector frozen even if a higher line arrives, mask changes or GIE clears.
//    On int_ack: PEND[int_id]<=0, INSV[int_id]<=1, GIE unchanged -> IDLE. No timeout.
//   IDLE re-evaluates the cycle after ack, so minimum gap between two requests is 1 idle cycle.
//  Latency: edge on int_e at cycle t -> PEND at t+1 -> int_req=1 at t+2 (when eligible and IDLE).
//  int_ret: clears lowest set bit of INSV (current level). Ignored if INSV==0. Legal in any state.
//  Same-cycle int_ret and int_ack: ret applied to INSV before ack's set; both take effect that edge.
//  int_ack while IDLE: ignored, no state change.
//  Max nesting depth = N_INT by construction (one INSV bit per level); no stack inside this block.
// TESTING
//  1 Reset, MASK=16'h8001, pulse int_e[0] -> int_req=1 two cycles later, int_id=0, int_vector=16'h0010.
//  2 MASK=16'h80FF, VBASE=16'h0100, rising edges on int_e[5] and int_e[2] same cycle -> int_id=2,
//    vector 16'h0108; ack -> INSV=8'h04; next request int_id=5 blocked until int_ret, then vector 16'h0114.
//  3 Nesting: in service 4 (INSV=8'h10), edge on int_e[1] -> request id 1, ack -> INSV=8'h12;
//    int_ret -> INSV=8'h10; int_ret -> INSV=0. Edge on int_e[6] during INSV=8'h10 -> no request.
//  4 GIE=0 with PEND=8'h08 -> int_req stays 0; set GIE -> int_req=1 id 3; clear GIE while in REQ ->
//    int_req held until ack.
//  5 Write PEND=8'h08 (W1C) same cycle as new edge on int_e[3] -> PEND[3] stays 1;
//    int_e[3] held high 10 cycles -> only one request.
//  6 VBASE=16'hFFF8, id 3 -> int_vector=16'h0004 (wrap); reset asserted during REQ -> int_req=0,
//    INSV=0, PEND=0 next cycle.

Source files
------------

// File: rtl/interrupt_controller.sv
// interrupt_controller
// Prioritised, vectored interrupt controller. Rising edges on int_e latch
// into PEND. A pending, enabled line that is not in service is eligible, and
// the lowest index among them wins. When the controller is idle and the
// winner outranks every level already in service, it raises int_req with a
// frozen int_id/int_vector until the CPU acknowledges. INSV tracks nested
// levels, and reti retires the highest-priority one (the lowest set bit).
module interrupt_controller #(
   parameter int          N_INT        = 8,
   parameter int          VEC_STRIDE   = 4,
   parameter logic [15:0] VEC_BASE_RST = 16'h0010
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_INT-1:0]         int_e,
   input  logic                     we,
   input  logic [1:0]               addr,
   input  logic [15:0]              wdata,
   output logic [15:0]              rdata,
   input  logic                     int_ack,
   input  logic                     int_ret,
   output logic                     int_req,
   output logic [15:0]              int_vector,
   output logic [$clog2(N_INT)-1:0] int_id
);

   localparam int          ID_W     = $clog2(N_INT);
   localparam logic [15:0] STRIDE_W = 16'(VEC_STRIDE);
   localparam logic [1:0]  A_MASK   = 2'd0;
   localparam logic [1:0]  A_PEND   = 2'd1;
   localparam logic [1:0]  A_INSV   = 2'd2;
   localparam logic [1:0]  A_VBASE  = 2'd3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } state_t;

   // Index of the lowest set bit, which is the highest priority; returns 0 for an empty vector.
   function automatic logic [ID_W-1:0] lowest_idx(input logic [N_INT-1:0] v);
      logic [ID_W-1:0] idx;
      idx = {ID_W{1'b0}};
      for (int i = N_INT - 1; i >= 0; i--) begin
         idx = v[i] ? ID_W'(i) : idx;
      end
      return idx;
   endfunction

   // One-hot mask of the lowest set bit; returns zero for an empty vector.
   function automatic logic [N_INT-1:0] lowest_bit(input logic [N_INT-1:0] v);
      return v & (~v + {{(N_INT-1){1'b0}}, 1'b1});
   endfunction

   state_t           state_r;
   logic [N_INT-1:0] prev_e_r;
   logic [N_INT-1:0] pend_r;
   logic [N_INT-1:0] insv_r;
   logic [N_INT-1:0] mask_r;
   logic             gie_r;
   logic [15:0]      vbase_r;

   logic [N_INT-1:0] edge_s;
   logic [N_INT-1:0] w1c_s;
   logic             ack_take_s;
   logic [N_INT-1:0] ack_bit_s;
   logic [N_INT-1:0] elig_s;
   logic [ID_W-1:0]  win_s;
   logic [ID_W-1:0]  insv_lvl_s;
   logic             requestable_s;
   logic [15:0]      vec_calc_s;
   logic [N_INT-1:0] insv_ret_s;

   // Rising edges only, so a line held high does not re-trigger.
   assign edge_s = int_e & ~prev_e_r;

   // Write-1-to-clear mask for PEND, active only on a PEND write.
   assign w1c_s = (we && (addr == A_PEND)) ? wdata[N_INT-1:0] : {N_INT{1'b0}};

   // An acknowledge counts only while a request is being presented.
   assign ack_take_s = (state_r == ST_REQ) && int_ack;
   assign ack_bit_s  = ack_take_s ? ({{(N_INT-1){1'b0}}, 1'b1} << int_id) : {N_INT{1'b0}};

   // Winner selection with nesting: the winner must strictly outrank the current level.
   assign elig_s        = pend_r & mask_r & ~insv_r & {N_INT{gie_r}};
   assign win_s         = lowest_idx(elig_s);
   assign insv_lvl_s    = lowest_idx(insv_r);
   assign requestable_s = (|elig_s) && ((insv_r == {N_INT{1'b0}}) || (win_s < insv_lvl_s));
   assign vec_calc_s    = vbase_r + (16'(win_s) * STRIDE_W);

   // reti retires the current level first, so a same-cycle ack sets its bit on top of that.
   assign insv_ret_s = int_ret ? (insv_r & ~lowest_bit(insv_r)) : insv_r;

   // Configuration, pending and in-service state.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_e_r <= {N_INT{1'b0}};
         pend_r   <= {N_INT{1'b0}};
         insv_r   <= {N_INT{1'b0}};
         mask_r   <= {N_INT{1'b0}};
         gie_r    <= 1'b0;
         vbase_r  <= VEC_BASE_RST;
      end else begin
         prev_e_r <= int_e;
         pend_r   <= (pend_r & ~w1c_s & ~ack_bit_s) | edge_s;
         insv_r   <= insv_ret_s | ack_bit_s;
         if (we) begin
            case (addr)
               A_MASK: begin
                  mask_r <= wdata[N_INT-1:0];
                  gie_r  <= wdata[15];
               end
               A_VBASE: vbase_r <= wdata;
               default: begin
               end
            endcase
         end else begin
            mask_r  <= mask_r;
            vbase_r <= vbase_r;
         end
      end
   end

   // Request FSM: latch the winner in IDLE, hold it frozen in REQ until acknowledged.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         int_req    <= 1'b0;
         int_vector <= 16'h0000;
         int_id     <= {ID_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (requestable_s) begin
                  state_r    <= ST_REQ;
                  int_req    <= 1'b1;
                  int_id     <= win_s;
                  int_vector <= vec_calc_s;
               end else begin
                  int_req    <= 1'b0;
               end
            end
            ST_REQ: begin
               if (int_ack) begin
                  state_r <= ST_IDLE;
                  int_req <= 1'b0;
               end else begin
                  int_req <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               int_req <= 1'b0;
            end
         endcase
      end
   end

   // Register read mux; reserved bits read as zero.
   always_comb begin
      rdata = 16'h0000;
      case (addr)
         A_MASK:  rdata = {gie_r, {(15-N_INT){1'b0}}, mask_r};
         A_PEND:  rdata = {{(16-N_INT){1'b0}}, pend_r};
         A_INSV:  rdata = {{(16-N_INT){1'b0}}, insv_r};
         A_VBASE: rdata = vbase_r;
         default: rdata = 16'h0000;
      endcase
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Testbench for interrupt_controller: a table of per-cycle stimulus and
// expected outputs replayed through a scoreboard queue, followed by
// hand-written multi-cycle sequences.
module tb_interrupt_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  int_e;
   logic        we;
   logic [1:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        int_ack;
   logic        int_ret;
   logic        int_req;
   logic [15:0] int_vector;
   logic [2:0]  int_id;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   interrupt_controller dut (
      .clk        (clk),
      .reset      (reset),
      .int_e      (int_e),
      .we         (we),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .int_ack    (int_ack),
      .int_ret    (int_ret),
      .int_req    (int_req),
      .int_vector (int_vector),
      .int_id     (int_id)
   );

   typedef struct {
      logic        rst;
      logic        we;
      logic [1:0]  addr;
      logic [15:0] wdata;
      logic [7:0]  e;
      logic        ack;
      logic        ret;
      logic        req;
      logic [2:0]  id;
      logic [15:0] vec;
      logic        rd_chk;
      logic [15:0] rd;
   } vec_t;

   typedef struct {
      int          idx;
      logic        req;
      logic [2:0]  id;
      logic [15:0] vec;
      logic        rd_chk;
      logic [15:0] rd;
   } exp_t;

   vec_t tbl[$];
   exp_t sb[$];

   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic rst, input logic w, input logic [1:0] a, input logic [15:0] wd,
                      input logic [7:0] e, input logic ack, input logic ret,
                      input logic req, input logic [2:0] id, input logic [15:0] vec,
                      input logic rdc, input logic [15:0] rd);
      vec_t v;
      v.rst = rst; v.we = w; v.addr = a; v.wdata = wd; v.e = e; v.ack = ack; v.ret = ret;
      v.req = req; v.id = id; v.vec = vec; v.rd_chk = rdc; v.rd = rd;
      tbl.push_back(v);
   endtask

   // Drive one table row, queue its expectation, then compare just after the edge.
   task automatic apply(input vec_t v, input int idx);
      exp_t x;
      exp_t got;
      reset = v.rst; we = v.we; addr = v.addr; wdata = v.wdata;
      int_e = v.e; int_ack = v.ack; int_ret = v.ret;
      x.idx = idx; x.req = v.req; x.id = v.id; x.vec = v.vec; x.rd_chk = v.rd_chk; x.rd = v.rd;
      sb.push_back(x);
      tick();
      got = sb.pop_front();
      chk("req", got.idx, {15'd0, int_req}, {15'd0, got.req});
      if (got.req) begin
         chk("id", got.idx, {13'd0, int_id}, {13'd0, got.id});
         chk("vector", got.idx, int_vector, got.vec);
      end
      if (got.rd_chk) begin
         chk("rdata", got.idx, rdata, got.rd);
      end
   endtask

   // Wait a bounded number of cycles for int_req; an expired budget is a failure.
   task automatic wait_req(input string nm, input int budget);
      int n;
      n = 0;
      while (!int_req && n < budget) begin
         tick();
         n++;
      end
      chk(nm, 0, {15'd0, int_req}, 16'h0001);
   endtask

   task automatic idle_inputs();
      reset = 1'b0; we = 1'b0; addr = 2'd0; wdata = 16'h0000;
      int_e = 8'h00; int_ack = 1'b0; int_ret = 1'b0;
   endtask

   initial begin
      int acks;
      idle_inputs();
      reset = 1'b1;

      //   rst  we    addr  wdata     e      ack   ret   req   id    vector    rdc   rdata
      // reset state and single request
      add(1'b1, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      add(1'b0, 1'b0, 2'd3, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0010);
      add(1'b0, 1'b1, 2'd0, 16'h8001, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h8001);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h01, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0001);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 16'h0010, 1'b1, 16'h0001);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0001);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      // simultaneous edges on 5 and 2, lower level blocked until reti
      add(1'b0, 1'b1, 2'd3, 16'h0100, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0100);
      add(1'b0, 1'b1, 2'd0, 16'h80FF, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h80FF);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h24, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0024);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h24, 1'b0, 1'b0, 1'b1, 3'd2, 16'h0108, 1'b1, 16'h0024);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0004);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0020);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0020);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 16'h0114, 1'b0, 16'h0000);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0020);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      // nesting: 1 preempts 4, 6 waits until 4 retires
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0010);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0110, 1'b0, 16'h0000);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0010);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h02, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0002);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 3'd1, 16'h0104, 1'b0, 16'h0000);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0012);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0010);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h40, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0040);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0040);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 3'd6, 16'h0118, 1'b1, 16'h0000);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0040);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      // global enable gating, request held after GIE clears
      add(1'b0, 1'b1, 2'd0, 16'h00FF, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h00FF);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0008);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0008);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0008);
      add(1'b0, 1'b1, 2'd0, 16'h80FF, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h80FF);
      add(1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 16'h010C, 1'b0, 16'h0000);
      add(1'b0, 1'b1, 2'd0, 16'h00FF, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 16'h010C, 1'b1, 16'h00FF);
      add(1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 16'h010C, 1'b0, 16'h0000);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0008);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      // set beats same-cycle W1C, level-high line does not re-trigger, reserved MASK bits
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0008);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0008);
      add(1'b0, 1'b1, 2'd1, 16'h0008, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0008);
      add(1'b0, 1'b1, 2'd0, 16'hFFFF, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h80FF);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 16'h010C, 1'b1, 16'h0008);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h08, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0008);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h08, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      // vector wrap, reset in the middle of a request
      add(1'b0, 1'b1, 2'd3, 16'hFFF8, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'hFFF8);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0010);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 16'h0008, 1'b0, 16'h0000);
      add(1'b0, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0010);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0008);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 16'h0004, 1'b1, 16'h0008);
      add(1'b1, 1'b0, 2'd2, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      add(1'b0, 1'b0, 2'd0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);
      add(1'b0, 1'b0, 2'd3, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0010);
      // plain W1C clear of a pending bit
      add(1'b0, 1'b0, 2'd1, 16'h0000, 8'h04, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0004);
      add(1'b0, 1'b1, 2'd1, 16'h0004, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 16'h0000);

      for (int i = 0; i < tbl.size(); i++) begin
         apply(tbl[i], i);
      end

      // Line held high for 12 cycles yields exactly one request.
      idle_inputs();
      we = 1'b1; addr = 2'd0; wdata = 16'h80FF;
      tick();
      we = 1'b0;
      acks = 0;
      for (int i = 0; i < 12; i++) begin
         int_e = 8'h08;
         int_ack = int_req;
         tick();
         if (int_ack) acks++;
      end
      int_ack = 1'b0;
      chk("level_once", 0, 16'(acks), 16'd1);
      int_e = 8'h00; int_ret = 1'b1; addr = 2'd2;
      tick();
      int_ret = 1'b0;
      chk("level_insv", 0, rdata, 16'h0000);

      // Same-cycle reti and ack: 4 retires, 1 enters service.
      int_e = 8'h10;
      tick();
      int_e = 8'h00;
      wait_req("req4_wait", 8);
      chk("req4_id", 0, {13'd0, int_id}, 16'd4);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      int_e = 8'h02;
      tick();
      int_e = 8'h00;
      wait_req("req1_wait", 8);
      chk("req1_vec", 0, int_vector, 16'h0014);
      int_ack = 1'b1; int_ret = 1'b1; addr = 2'd2;
      tick();
      int_ack = 1'b0; int_ret = 1'b0;
      chk("ackret_insv", 0, rdata, 16'h0002);
      chk("ackret_req", 0, {15'd0, int_req}, 16'h0000);
      int_ret = 1'b1;
      tick();
      int_ret = 1'b0;
      chk("ackret_clr", 0, rdata, 16'h0000);

      // Ack while IDLE is ignored: no INSV change, request still raised.
      int_e = 8'h04;
      tick();
      int_e = 8'h00;
      chk("idle_req0", 0, {15'd0, int_req}, 16'h0000);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      chk("idle_ack_req", 0, {15'd0, int_req}, 16'h0001);
      chk("idle_ack_insv", 0, rdata, 16'h0000);
      int_ack = 1'b1;
      tick();
      int_ack = 1'b0;
      chk("real_ack_insv", 0, rdata, 16'h0004);
      int_ret = 1'b1;
      tick();
      int_ret = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
